// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes and branch opcode constants
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] ALU_SLL   = 6'h00;
    localparam logic [5:0] ALU_PASSB = 6'h01;
    localparam logic [5:0] ALU_SRL   = 6'h02;
    localparam logic [5:0] ALU_SRA   = 6'h03;
    localparam logic [5:0] ALU_SLLV  = 6'h04;
    localparam logic [5:0] ALU_SRLV  = 6'h06;
    localparam logic [5:0] ALU_SRAV  = 6'h07;
    localparam logic [5:0] ALU_LUI   = 6'h0F;
    localparam logic [5:0] ALU_MFHI  = 6'h10;
    localparam logic [5:0] ALU_MTHI  = 6'h11;
    localparam logic [5:0] ALU_MFLO  = 6'h12;
    localparam logic [5:0] ALU_MTLO  = 6'h13;
    localparam logic [5:0] ALU_MULT  = 6'h18;
    localparam logic [5:0] ALU_MULTU = 6'h19;
    localparam logic [5:0] ALU_DIV   = 6'h1A;
    localparam logic [5:0] ALU_DIVU  = 6'h1B;
    localparam logic [5:0] ALU_ADD   = 6'h20;
    localparam logic [5:0] ALU_ADDU  = 6'h21;
    localparam logic [5:0] ALU_SUB   = 6'h22;
    localparam logic [5:0] ALU_SUBU  = 6'h23;
    localparam logic [5:0] ALU_AND   = 6'h24;
    localparam logic [5:0] ALU_OR    = 6'h25;
    localparam logic [5:0] ALU_XOR   = 6'h26;
    localparam logic [5:0] ALU_NOR   = 6'h27;
    localparam logic [5:0] ALU_SLT   = 6'h2A;
    localparam logic [5:0] ALU_SLTU  = 6'h2B;

    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;

    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

endpackage

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - combinational branch/jump taken decision
module branch_cmp
    import alu_pkg::*;
(
    input  logic        Jump,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] Instr,
    output logic        taken
);

    logic [5:0] opcode;
    logic [4:0] rt;
    logic       a_neg;
    logic       a_zero;
    logic       unused_instr;

    assign opcode       = Instr[31:26];
    assign rt           = Instr[20:16];
    assign a_neg        = A[31];
    assign a_zero       = (A == 32'h0);
    assign unused_instr = ^{Instr[25:21], Instr[15:0]};

    always_comb begin
        taken = 1'b0;
        if (Jump) begin
            taken = 1'b1;
        end else begin
            case (opcode)
                OP_BEQ:  taken = (A == B);
                OP_BNE:  taken = (A != B);
                OP_BLEZ: taken = a_neg | a_zero;
                OP_BGTZ: taken = ~a_neg & ~a_zero;
                OP_REGIMM: begin
                    // Linking variants resolve identically; the link write happens elsewhere.
                    case (rt)
                        RT_BLTZ, RT_BLTZAL: taken = a_neg;
                        RT_BGEZ, RT_BGEZAL: taken = ~a_neg;
                        default:            taken = 1'b0;
                    endcase
                end
                default: taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/alu_branch_unit.sv
// rtl/alu_branch_unit.sv - execute-stage ALU, HI/LO registers, branch decision (optional divider: ALU_DIV_EN)
module alu_branch_unit
    import alu_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        en,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [5:0]  ALU_control,
    input  logic [4:0]  shiftAmount,
    input  logic [31:0] Instr,
    input  logic        Jump,
    output logic [31:0] aluResult,
    output logic [31:0] HI_OUT,
    output logic [31:0] LO_OUT,
    output logic        taken
);

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;

    logic        div_ok;
    logic [31:0] div_sq, div_sr, div_uq, div_ur;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'h0, A} * {32'h0, B};

`ifdef ALU_DIV_EN
    logic        div_ovf;
    logic [31:0] div_b;

    // Steering the divisor to 1 for /0 and MIN/-1 keeps the arithmetic well defined;
    // MIN/1 already yields the required quotient 0x80000000 with remainder 0.
    assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign div_ok  = (B != 32'h0);
    assign div_b   = (!div_ok || div_ovf) ? 32'h1 : B;
    assign div_sq  = $signed(A) / $signed(div_b);
    assign div_sr  = $signed(A) % $signed(div_b);
    assign div_uq  = A / div_b;
    assign div_ur  = A % div_b;
`else
    assign div_ok  = 1'b0;
    assign div_sq  = 32'h0;
    assign div_sr  = 32'h0;
    assign div_uq  = 32'h0;
    assign div_ur  = 32'h0;
`endif

    always_comb begin
        aluResult = 32'h0;
        case (ALU_control)
            ALU_ADD, ALU_ADDU: aluResult = A + B;
            ALU_SUB, ALU_SUBU: aluResult = A - B;
            ALU_AND:           aluResult = A & B;
            ALU_OR:            aluResult = A | B;
            ALU_XOR:           aluResult = A ^ B;
            ALU_NOR:           aluResult = ~(A | B);
            ALU_SLT:           aluResult = {31'h0, ($signed(A) < $signed(B))};
            ALU_SLTU:          aluResult = {31'h0, (A < B)};
            ALU_SLL:           aluResult = B << shiftAmount;
            ALU_SRL:           aluResult = B >> shiftAmount;
            ALU_SRA:           aluResult = $signed(B) >>> shiftAmount;
            ALU_SLLV:          aluResult = B << A[4:0];
            ALU_SRLV:          aluResult = B >> A[4:0];
            ALU_SRAV:          aluResult = $signed(B) >>> A[4:0];
            ALU_LUI:           aluResult = {B[15:0], 16'h0};
            ALU_PASSB:         aluResult = B;
            ALU_MFHI:          aluResult = hi_q;
            ALU_MFLO:          aluResult = lo_q;
            default:           aluResult = 32'h0;
        endcase
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (en) begin
            case (ALU_control)
                ALU_MULT:  {hi_d, lo_d} = prod_s;
                ALU_MULTU: {hi_d, lo_d} = prod_u;
                ALU_DIV: begin
                    if (div_ok) begin
                        lo_d = div_sq;
                        hi_d = div_sr;
                    end
                end
                ALU_DIVU: begin
                    if (div_ok) begin
                        lo_d = div_uq;
                        hi_d = div_ur;
                    end
                end
                ALU_MTHI:  hi_d = A;
                ALU_MTLO:  lo_d = A;
                default: begin
                    hi_d = hi_q;
                    lo_d = lo_q;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hi_q <= 32'h0;
            lo_q <= 32'h0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign HI_OUT = hi_q;
    assign LO_OUT = lo_q;

    branch_cmp u_branch_cmp (
        .Jump  (Jump),
        .A     (A),
        .B     (B),
        .Instr (Instr),
        .taken (taken)
    );

endmodule

// File: tb/tb_alu_branch_unit.sv
// tb/tb_alu_branch_unit.sv - directed self-checking bench for alu_branch_unit
module tb_alu_branch_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        en;
    logic [31:0] A, B, Instr;
    logic [5:0]  ALU_control;
    logic [4:0]  shiftAmount;
    logic        Jump;
    logic [31:0] aluResult, HI_OUT, LO_OUT;
    logic        taken;

    int checks = 0;
    int errors = 0;

    alu_branch_unit dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .en          (en),
        .A           (A),
        .B           (B),
        .ALU_control (ALU_control),
        .shiftAmount (shiftAmount),
        .Instr       (Instr),
        .Jump        (Jump),
        .aluResult   (aluResult),
        .HI_OUT      (HI_OUT),
        .LO_OUT      (LO_OUT),
        .taken       (taken)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic [5:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic e);
        @(negedge CLK);
        ALU_control = ctrl;
        A           = a;
        B           = b;
        shiftAmount = sh;
        en          = e;
    endtask

    task automatic clock_op(input logic [5:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                            input logic e);
        drive(ctrl, a, b, 5'd0, e);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RESET = 1'b0;
        en = 1'b1; A = 32'h0; B = 32'h0; ALU_control = 6'h3F; shiftAmount = 5'd0;
        Instr = 32'h0; Jump = 1'b0;
        #1;
        checks++;
        if (HI_OUT !== 32'h0 || LO_OUT !== 32'h0) begin
            errors++;
            $display("FAIL reset_hilo hi=%h lo=%h expected 0/0", HI_OUT, LO_OUT);
        end
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        drive(6'h10, 32'h0, 32'h0, 5'd0, 1'b1);
        #1;
        checks++;
        if (aluResult !== 32'h0) begin
            errors++;
            $display("FAIL reset_mfhi got=%h expected=00000000", aluResult);
        end
        drive(6'h12, 32'h0, 32'h0, 5'd0, 1'b1);
        #1;
        checks++;
        if (aluResult !== 32'h0) begin
            errors++;
            $display("FAIL reset_mflo got=%h expected=00000000", aluResult);
        end
    endtask

    typedef struct {
        logic [5:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] exp;
    } alu_vec_t;

    task automatic test_alu_ops;
        alu_vec_t v[18];
        v[0]  = '{6'h20, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000};
        v[1]  = '{6'h21, 32'hFFFFFFFF, 32'h00000002, 5'd0, 32'h00000001};
        v[2]  = '{6'h22, 32'h00000000, 32'h00000001, 5'd0, 32'hFFFFFFFF};
        v[3]  = '{6'h24, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0, 32'h00F0F000};
        v[4]  = '{6'h25, 32'hF0000000, 32'h0000000F, 5'd0, 32'hF000000F};
        v[5]  = '{6'h26, 32'hAAAA5555, 32'hFFFF0000, 5'd0, 32'h55555555};
        v[6]  = '{6'h27, 32'h0000FFFF, 32'h00FF0000, 5'd0, 32'hFF000000};
        v[7]  = '{6'h2A, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001};
        v[8]  = '{6'h2B, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000};
        v[9]  = '{6'h03, 32'h00000000, 32'h80000000, 5'd4, 32'hF8000000};
        v[10] = '{6'h02, 32'h00000000, 32'h80000000, 5'd4, 32'h08000000};
        v[11] = '{6'h00, 32'h00000000, 32'h00000003, 5'd31, 32'h80000000};
        v[12] = '{6'h06, 32'h00000024, 32'h80000000, 5'd0, 32'h08000000};
        v[13] = '{6'h07, 32'h00000024, 32'h80000000, 5'd0, 32'hF8000000};
        v[14] = '{6'h04, 32'h00000021, 32'h00000001, 5'd0, 32'h00000002};
        v[15] = '{6'h0F, 32'h00000000, 32'hABCD1234, 5'd0, 32'h12340000};
        v[16] = '{6'h01, 32'h11111111, 32'hCAFEBABE, 5'd0, 32'hCAFEBABE};
        v[17] = '{6'h3F, 32'h12345678, 32'h9ABCDEF0, 5'd0, 32'h00000000};
        for (int i = 0; i < 18; i++) begin
            drive(v[i].ctrl, v[i].a, v[i].b, v[i].sh, 1'b1);
            #1;
            checks++;
            if (aluResult !== v[i].exp) begin
                errors++;
                $display("FAIL alu_op[%0d] ctrl=%h got=%h expected=%h", i, v[i].ctrl, aluResult, v[i].exp);
            end
        end
    endtask

    task automatic test_mult;
        clock_op(6'h18, 32'hFFFFFFFE, 32'h00000003, 1'b1);
        checks++;
        if (HI_OUT !== 32'hFFFFFFFF || LO_OUT !== 32'hFFFFFFFA) begin
            errors++;
            $display("FAIL mult hi=%h lo=%h expected FFFFFFFF/FFFFFFFA", HI_OUT, LO_OUT);
        end
        clock_op(6'h19, 32'hFFFFFFFE, 32'h00000003, 1'b1);
        checks++;
        if (HI_OUT !== 32'h00000002 || LO_OUT !== 32'hFFFFFFFA) begin
            errors++;
            $display("FAIL multu hi=%h lo=%h expected 00000002/FFFFFFFA", HI_OUT, LO_OUT);
        end
        drive(6'h12, 32'h0, 32'h0, 5'd0, 1'b1);
        #1;
        checks++;
        if (aluResult !== 32'hFFFFFFFA) begin
            errors++;
            $display("FAIL mflo_after_mult got=%h expected=FFFFFFFA", aluResult);
        end
        drive(6'h18, 32'h12345678, 32'h9ABCDEF0, 5'd0, 1'b1);
        #1;
        checks++;
        if (aluResult !== 32'h0) begin
            errors++;
            $display("FAIL mult_result got=%h expected=00000000", aluResult);
        end
    endtask

    task automatic test_div;
        logic [31:0] exp_hi, exp_lo;
        clock_op(6'h11, 32'h11111111, 32'h0, 1'b1);
        clock_op(6'h13, 32'h22222222, 32'h0, 1'b1);
        checks++;
        if (HI_OUT !== 32'h11111111 || LO_OUT !== 32'h22222222) begin
            errors++;
            $display("FAIL mthi_mtlo hi=%h lo=%h expected 11111111/22222222", HI_OUT, LO_OUT);
        end
        clock_op(6'h1A, 32'hFFFFFFF9, 32'h00000002, 1'b1);
`ifdef ALU_DIV_EN
        exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFFD;
`else
        exp_hi = 32'h11111111; exp_lo = 32'h22222222;
`endif
        checks++;
        if (HI_OUT !== exp_hi || LO_OUT !== exp_lo) begin
            errors++;
            $display("FAIL div_neg hi=%h lo=%h expected %h/%h", HI_OUT, LO_OUT, exp_hi, exp_lo);
        end
        clock_op(6'h1A, 32'h00000064, 32'h00000000, 1'b1);
        checks++;
        if (HI_OUT !== exp_hi || LO_OUT !== exp_lo) begin
            errors++;
            $display("FAIL div_by_zero hi=%h lo=%h expected %h/%h", HI_OUT, LO_OUT, exp_hi, exp_lo);
        end
        clock_op(6'h1A, 32'h80000000, 32'hFFFFFFFF, 1'b1);
`ifdef ALU_DIV_EN
        exp_hi = 32'h00000000; exp_lo = 32'h80000000;
`endif
        checks++;
        if (HI_OUT !== exp_hi || LO_OUT !== exp_lo) begin
            errors++;
            $display("FAIL div_overflow hi=%h lo=%h expected %h/%h", HI_OUT, LO_OUT, exp_hi, exp_lo);
        end
        clock_op(6'h1B, 32'hFFFFFFF9, 32'h00000002, 1'b1);
`ifdef ALU_DIV_EN
        exp_hi = 32'h00000001; exp_lo = 32'h7FFFFFFC;
`endif
        checks++;
        if (HI_OUT !== exp_hi || LO_OUT !== exp_lo) begin
            errors++;
            $display("FAIL divu hi=%h lo=%h expected %h/%h", HI_OUT, LO_OUT, exp_hi, exp_lo);
        end
        clock_op(6'h11, 32'h00000055, 32'h0, 1'b0);
        checks++;
        if (HI_OUT !== exp_hi) begin
            errors++;
            $display("FAIL mthi_en0 hi=%h expected=%h", HI_OUT, exp_hi);
        end
        clock_op(6'h18, 32'h00000002, 32'h00000003, 1'b0);
        checks++;
        if (HI_OUT !== exp_hi || LO_OUT !== exp_lo) begin
            errors++;
            $display("FAIL mult_en0 hi=%h lo=%h expected %h/%h", HI_OUT, LO_OUT, exp_hi, exp_lo);
        end
        clock_op(6'h3E, 32'hDEADBEEF, 32'h00000001, 1'b1);
        checks++;
        if (HI_OUT !== exp_hi || LO_OUT !== exp_lo) begin
            errors++;
            $display("FAIL unknown_code_hilo hi=%h lo=%h expected %h/%h", HI_OUT, LO_OUT, exp_hi, exp_lo);
        end
    endtask

    typedef struct {
        logic        jmp;
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp;
    } br_vec_t;

    task automatic test_branch;
        br_vec_t v[12];
        v[0]  = '{1'b0, 32'h10000000, 32'h00000005, 32'h00000005, 1'b1};
        v[1]  = '{1'b0, 32'h14000000, 32'h00000005, 32'h00000005, 1'b0};
        v[2]  = '{1'b0, 32'h18000000, 32'h00000000, 32'h00000000, 1'b1};
        v[3]  = '{1'b0, 32'h1C000000, 32'h80000000, 32'h00000000, 1'b0};
        v[4]  = '{1'b0, 32'h04010000, 32'h00000000, 32'h00000000, 1'b1};
        v[5]  = '{1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
        v[6]  = '{1'b1, 32'h00000000, 32'h00000000, 32'h00000001, 1'b1};
        v[7]  = '{1'b0, 32'h20000000, 32'h00000005, 32'h00000005, 1'b0};
        v[8]  = '{1'b0, 32'h04000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        v[9]  = '{1'b0, 32'h04110000, 32'h00000001, 32'h00000000, 1'b1};
        v[10] = '{1'b0, 32'h04050000, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        v[11] = '{1'b0, 32'h1C000000, 32'h00000001, 32'h00000000, 1'b1};
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            Jump  = v[i].jmp;
            Instr = v[i].instr;
            A     = v[i].a;
            B     = v[i].b;
            en    = 1'b0;
            #1;
            checks++;
            if (taken !== v[i].exp) begin
                errors++;
                $display("FAIL branch[%0d] instr=%h got=%b expected=%b", i, v[i].instr, taken, v[i].exp);
            end
        end
        Jump = 1'b0;
    endtask

    task automatic test_async_reset;
        clock_op(6'h18, 32'hFFFFFFFE, 32'h00000003, 1'b1);
        drive(6'h3F, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
        RESET = 1'b0;
        #1;
        checks++;
        if (HI_OUT !== 32'h0 || LO_OUT !== 32'h0) begin
            errors++;
            $display("FAIL async_reset hi=%h lo=%h expected 0/0", HI_OUT, LO_OUT);
        end
        @(negedge CLK);
        RESET = 1'b1;
        clock_op(6'h13, 32'h0000ABCD, 32'h0, 1'b1);
        checks++;
        if (LO_OUT !== 32'h0000ABCD || HI_OUT !== 32'h0) begin
            errors++;
            $display("FAIL mtlo_after_reset hi=%h lo=%h expected 00000000/0000ABCD", HI_OUT, LO_OUT);
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_mult();
        test_div();
        test_branch();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_branch_unit.md
Name: alu_branch_unit

Overview:
- Execute-stage datapath of the in-order MIPS pipeline; sits between decode/issue and MEM.
- Combinational 32-bit integer ALU: arithmetic, logic, shifts, set-less-than, LUI, HI/LO moves.
- Owns the architectural HI/LO registers, written by multiply/divide/MT ops.
- Produces a combinational branch/jump "taken" decision from the instruction word and operands.

Parameters:
- none (widths fixed: 32-bit data, 6-bit ALU control, 5-bit shift amount)

Ports:
- CLK input 1: clock, rising edge.
- RESET input 1: asynchronous, active-low reset.
- en input 1: operation valid; 0 marks a bubble, and HI/LO are not written.
- A input 32: operand A (rs).
- B input 32: operand B (rt or immediate).
- ALU_control input 6: operation select.
- shiftAmount input 5: shamt for immediate shifts.
- Instr input 32: instruction word for branch decode.
- Jump input 1: unconditional jump/jump-register indication.
- aluResult output 32: combinational result.
- HI_OUT output 32: current HI register.
- LO_OUT output 32: current LO register.
- taken output 1: combinational control-transfer request.

Behaviour:
- Reset (RESET=0, asynchronous): HI=0, LO=0 immediately. All other outputs are combinational and follow the inputs.

ALU_control encoding (hex); aluResult is combinational:
- 20 ADD, 21 ADDU: A+B mod 2^32. No overflow trap.
- 22 SUB, 23 SUBU: A-B mod 2^32.
- 24 AND, 25 OR, 26 XOR, 27 NOR.
- 2A SLT: signed A<B gives 1, else 0. 2B SLTU: unsigned compare.
- 00 SLL, 02 SRL, 03 SRA: shift B by shiftAmount.
- 04 SLLV, 06 SRLV, 07 SRAV: shift B by A[4:0].
- 0F LUI: {B[15:0],16'h0}.
- 01 PASSB: B.
- 10 MFHI: current HI register. 12 MFLO: current LO register.
- 11 MTHI, 13 MTLO, 18 MULT, 19 MULTU, 1A DIV, 1B DIVU: aluResult=0.
- Any other code: aluResult=0, no HI/LO write.

HI/LO update (rising CLK, only when en=1):
- MULT: {HI,LO} = signed 64-bit A*B. MULTU: unsigned product.
- DIV: LO = signed quotient truncated toward zero; HI = remainder, same sign as A. DIVU: unsigned quotient/remainder.
- Divide by B=0: HI and LO unchanged.
- DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI: HI<=A. MTLO: LO<=A.
- Latency is 1 cycle: MFHI/MFLO in the cycle directly after a writer returns the new value. MFHI in the same cycle as a writer is impossible because there is one op per cycle.
- RESET asserted mid-cycle clears HI/LO regardless of en or ALU_control.

taken (combinational):
- Jump=1 gives 1.
- Otherwise decode on Instr[31:26], with signed compares:
  - 04 BEQ: A==B. 05 BNE: A!=B.
  - 06 BLEZ: A<=0. 07 BGTZ: A>0.
  - 01 REGIMM, selected by Instr[20:16]: 00 BLTZ A<0; 01 BGEZ A>=0; 10 BLTZAL A<0; 11 BGEZAL A>=0. Other rt values give 0.
  - All other opcodes give 0.
- taken does not depend on en, CLK or RESET.

Optional Feature:
- ALU_DIV_EN defined: DIV/DIVU implemented as above. Single-cycle combinational divider.
- ALU_DIV_EN undefined: no divider is synthesized. DIV/DIVU behave as unknown codes: aluResult=0, HI/LO unchanged.

Decomposition:
- Shared package alu_pkg:
  - ALU_control localparams (ALU_ADD ... ALU_DIVU).
  - Opcode constants OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ.
  - REGIMM rt constants.
- One sub-module, branch_cmp: inputs Jump, A, B, Instr; output taken. Purely combinational, instantiated once.
- ALU datapath and the HI/LO register live in alu_branch_unit.

Test Plan:
- Reset, then MFHI/MFLO with en=1: aluResult=0 both. ADD A=7FFFFFFF B=1 gives 80000000. SUB 0-1 gives FFFFFFFF.
- SLT A=FFFFFFFF B=1 gives 1; SLTU gives 0. SRA B=80000000 shamt=4 gives F8000000. SRLV A=24 (A[4:0]=4) gives 08000000. LUI B=1234 gives 12340000.
- MULT A=FFFFFFFE B=3, clock: HI=FFFFFFFF, LO=FFFFFFFA. MULTU same operands: HI=2, LO=FFFFFFFA. MFLO next cycle gives FFFFFFFA.
- DIV A=FFFFFFF9 (-7) B=2: LO=FFFFFFFD, HI=FFFFFFFF. DIV by 0: HI/LO unchanged. MTHI A=55 with en=0: HI unchanged. Without ALU_DIV_EN: DIV leaves HI/LO unchanged.
- BEQ (Instr[31:26]=04) A=B=5 gives taken=1; BNE same operands gives 0. BLEZ A=0 gives 1. BGTZ A=80000000 gives 0. REGIMM rt=01 A=0 gives 1. Jump=1 with opcode 00 gives 1. Opcode 08 gives 0.
- Assert RESET low between clock edges after MULT: HI/LO read 0 immediately. Release reset, then MTLO A=ABCD: LO=ABCD after the next edge.
